// File: rtl/posit_round_encode.sv
// Final posit pipeline stage: packs sign, scaling factor and normalized fraction into a posit
// with round-to-nearest-even, saturation and sign negation over a two-stage valid/ready pipe.
module posit_round_encode #(
   parameter int  posit_width = 8,
   parameter int  es          = 1,
   localparam int scale_width = es + $clog2(posit_width) + 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [posit_width-1:0]        in_frac,
   input  logic                          in_sign,
   input  logic signed [scale_width-1:0] in_sf,
   input  logic                          in_zero,
   input  logic                          in_exception,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [posit_width-1:0]        out_posit,
   output logic                          out_sat
);

   localparam int k_w    = scale_width - es;
   localparam int frac_w = posit_width - 1;
   // regime (up to posit_width bits) + exponent + fraction, with room below for shifted-out bits
   localparam int str_w  = 2 + es + frac_w + posit_width;

   localparam logic signed [scale_width-1:0] sf_hi = scale_width'((posit_width - 2) << es);
   localparam logic signed [scale_width-1:0] sf_lo = -sf_hi;

   localparam logic [posit_width-1:0] maxpos = {1'b0, {(posit_width-1){1'b1}}};
   localparam logic [posit_width-1:0] minpos = posit_width'(1);
   localparam logic [posit_width-1:0] nar    = {1'b1, {(posit_width-1){1'b0}}};

   // Returns {sat, magnitude}; never lets rounding reach NaR or zero.
   function automatic logic [posit_width:0] round_rne(
      input logic [frac_w-1:0] body,
      input logic              guard,
      input logic              sticky
   );
      logic                   inc;
      logic [posit_width-1:0] sum;
      inc = guard & (sticky | body[0]);
      sum = {1'b0, body} + posit_width'(inc);
      if (sum[posit_width-1])
         round_rne = {1'b1, maxpos};
      else if (sum == '0)
         round_rne = {1'b1, minpos};
      else
         round_rne = {1'b0, sum};
   endfunction

   function automatic logic [posit_width-1:0] apply_sign(
      input logic [posit_width-1:0] mag,
      input logic                   neg
   );
      apply_sign = neg ? (~mag + posit_width'(1)) : mag;
   endfunction

   logic hidden_unused;
   assign hidden_unused = in_frac[posit_width-1];

   logic vld_p1, vld_p2;
   logic adv_p1;

   assign adv_p1    = !vld_p2 || out_ready;
   assign in_ready  = !vld_p1 || adv_p1;
   assign out_valid = vld_p2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         if (in_ready)
            vld_p1 <= in_valid;
         if (adv_p1)
            vld_p2 <= vld_p1;
      end
   end

   // ---- stage 1: split scaling factor, classify special/clamped results ----
   logic                    clamp_hi_p0, clamp_lo_p0;
   logic                    sign_p1, zero_p1, nar_p1, force_max_p1, force_min_p1;
   logic signed [k_w-1:0]   k_p1;
   logic [es-1:0]           e_p1;
   logic [frac_w-1:0]       f_p1;

   assign clamp_hi_p0 = in_sf > sf_hi;
   assign clamp_lo_p0 = in_sf < sf_lo;

   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         sign_p1      <= in_sign;
         nar_p1       <= in_exception;
         zero_p1      <= in_zero & ~in_exception;
         force_max_p1 <= ~in_exception & ~in_zero & clamp_hi_p0;
         force_min_p1 <= ~in_exception & ~in_zero & clamp_lo_p0;
         k_p1         <= in_sf[scale_width-1:es];
         e_p1         <= in_sf[es-1:0];
         f_p1         <= in_frac[frac_w-1:0];
      end
   end

   // ---- stage 2: build regime string, round, negate ----
   logic signed [str_w-1:0] str_p1, shifted_p1;
   logic [k_w-1:0]          shamt_p1;
   logic [frac_w-1:0]       body_p1;
   logic                    guard_p1, sticky_p1;
   logic [posit_width:0]    rounded_p1;
   logic [posit_width-1:0]  posit_p1;
   logic                    sat_p1;

   always_comb begin
      // k>=0 seeds "10" and smears ones right; k<0 seeds "01" and smears zeros right.
      shamt_p1   = k_p1[k_w-1] ? ~k_p1 : k_p1;
      str_p1     = {~k_p1[k_w-1], k_p1[k_w-1], e_p1, f_p1, {posit_width{1'b0}}};
      shifted_p1 = str_p1 >>> shamt_p1;
      body_p1    = shifted_p1[str_w-1 -: frac_w];
      guard_p1   = shifted_p1[str_w-1-frac_w];
      sticky_p1  = |shifted_p1[str_w-2-frac_w:0];
      rounded_p1 = round_rne(body_p1, guard_p1, sticky_p1);

      posit_p1 = apply_sign(rounded_p1[posit_width-1:0], sign_p1);
      sat_p1   = rounded_p1[posit_width];
      if (nar_p1) begin
         posit_p1 = nar;
         sat_p1   = 1'b0;
      end else if (zero_p1) begin
         posit_p1 = '0;
         sat_p1   = 1'b0;
      end else if (force_max_p1) begin
         posit_p1 = apply_sign(maxpos, sign_p1);
         sat_p1   = 1'b1;
      end else if (force_min_p1) begin
         posit_p1 = apply_sign(minpos, sign_p1);
         sat_p1   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_posit <= '0;
         out_sat   <= 1'b0;
      end else if (adv_p1 && vld_p1) begin
         out_posit <= posit_p1;
         out_sat   <= sat_p1;
      end
   end

endmodule

// File: tb/tb_posit_round_encode.sv
// Directed bench for posit_round_encode (N=8, es=1): vector table, backpressure and
// mid-stream reset sequences.
module tb_posit_round_encode;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_frac;
   logic              in_sign;
   logic signed [4:0] in_sf;
   logic              in_zero;
   logic              in_exception;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        out_posit;
   logic              out_sat;

   int n_cmp  = 0;
   int n_fail = 0;

   posit_round_encode #(.posit_width(8), .es(1)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_frac(in_frac), .in_sign(in_sign), .in_sf(in_sf),
      .in_zero(in_zero), .in_exception(in_exception),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_posit(out_posit), .out_sat(out_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]        frac;
      logic              sign;
      logic signed [4:0] sf;
      logic              zero;
      logic              exc;
      logic [7:0]        posit;
      logic              sat;
   } vec_t;

   vec_t vecs[18];
   vec_t bp[4];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      in_frac      = v.frac;
      in_sign      = v.sign;
      in_sf        = v.sf;
      in_zero      = v.zero;
      in_exception = v.exc;
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      int t;
      @(negedge clk);
      drive(v);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      t = 0;
      while (!in_ready && t < 10) begin
         @(negedge clk);
         #1;
         t++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      t = 0;
      while (!out_valid && t < 10) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) begin
         n_cmp++;
         n_fail++;
         $display("FAIL vec%0d_timeout: out_valid got 0 expected 1", idx);
      end else begin
         check($sformatf("vec%0d_posit", idx), out_posit, v.posit);
         check($sformatf("vec%0d_sat", idx), 8'(out_sat), 8'(v.sat));
      end
   endtask

   initial begin
      int  ii, oo;
      logic [7:0] held;
      logic stalled_prev;
      logic acc;

      vecs[0]  = '{8'h80, 1'b0,  5'sd0,  1'b0, 1'b0, 8'h40, 1'b0};
      vecs[1]  = '{8'h80, 1'b1,  5'sd0,  1'b0, 1'b0, 8'hC0, 1'b0};
      vecs[2]  = '{8'hC0, 1'b0,  5'sd0,  1'b0, 1'b0, 8'h48, 1'b0};
      vecs[3]  = '{8'h85, 1'b0,  5'sd0,  1'b0, 1'b0, 8'h41, 1'b0};
      vecs[4]  = '{8'h84, 1'b0,  5'sd0,  1'b0, 1'b0, 8'h40, 1'b0};
      vecs[5]  = '{8'h8C, 1'b0,  5'sd0,  1'b0, 1'b0, 8'h42, 1'b0};
      vecs[6]  = '{8'h80, 1'b0,  5'sd12, 1'b0, 1'b0, 8'h7F, 1'b0};
      vecs[7]  = '{8'h80, 1'b0,  5'sd13, 1'b0, 1'b0, 8'h7F, 1'b1};
      vecs[8]  = '{8'h80, 1'b0, -5'sd12, 1'b0, 1'b0, 8'h01, 1'b0};
      vecs[9]  = '{8'h80, 1'b0, -5'sd14, 1'b0, 1'b0, 8'h01, 1'b1};
      vecs[10] = '{8'h80, 1'b1,  5'sd15, 1'b0, 1'b0, 8'h81, 1'b1};
      vecs[11] = '{8'h80, 1'b1,  5'sd3,  1'b1, 1'b0, 8'h00, 1'b0};
      vecs[12] = '{8'h80, 1'b1,  5'sd15, 1'b1, 1'b1, 8'h80, 1'b0};
      vecs[13] = '{8'h80, 1'b0,  5'sd1,  1'b0, 1'b0, 8'h50, 1'b0};
      vecs[14] = '{8'h80, 1'b0, -5'sd1,  1'b0, 1'b0, 8'h30, 1'b0};
      vecs[15] = '{8'hC0, 1'b0,  5'sd2,  1'b0, 1'b0, 8'h64, 1'b0};
      vecs[16] = '{8'hFF, 1'b0,  5'sd11, 1'b0, 1'b0, 8'h7F, 1'b0};
      vecs[17] = '{8'h85, 1'b1,  5'sd0,  1'b0, 1'b0, 8'hBF, 1'b0};

      bp[0] = vecs[0];
      bp[1] = vecs[13];
      bp[2] = vecs[14];
      bp[3] = vecs[15];

      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      drive(vecs[0]);
      @(negedge clk);
      @(negedge clk);
      check("reset_out_valid", 8'(out_valid), 8'h00);
      check("reset_out_posit", out_posit, 8'h00);
      check("reset_out_sat", 8'(out_sat), 8'h00);
      reset = 1'b0;

      for (int i = 0; i < 18; i++)
         apply_vec(vecs[i], i);

      // backpressure: out_ready low for the first five cycles, then drain
      @(negedge clk);
      ii = 0;
      oo = 0;
      held = '0;
      stalled_prev = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         out_ready = (c >= 5);
         if (ii < 4) begin
            drive(bp[ii]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (c < 5)
            check($sformatf("bp_in_ready_c%0d", c), 8'(in_ready), 8'(ii < 2));
         if (stalled_prev)
            check($sformatf("bp_stable_c%0d", c), out_posit, held);
         if (out_valid && out_ready) begin
            if (oo < 4) begin
               check($sformatf("bp_order%0d", oo), out_posit, bp[oo].posit);
            end else begin
               n_cmp++;
               n_fail++;
               $display("FAIL bp_extra: got output %02h expected none", out_posit);
            end
            oo++;
         end
         stalled_prev = out_valid && !out_ready;
         held = out_posit;
         acc = in_valid && in_ready;
         if (acc)
            ii++;
      end
      check("bp_accepted", 8'(ii), 8'd4);
      check("bp_delivered", 8'(oo), 8'd4);

      // reset with two beats in flight
      @(negedge clk);
      out_ready = 1'b0;
      drive(vecs[6]);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      drive(vecs[2]);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_pre_out_valid", 8'(out_valid), 8'h01);
      #2;
      reset = 1'b1;
      #1;
      check("rst_out_valid", 8'(out_valid), 8'h00);
      check("rst_out_posit", out_posit, 8'h00);
      check("rst_in_ready", 8'(in_ready), 8'h01);
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      drive(vecs[14]);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_lat1_out_valid", 8'(out_valid), 8'h00);
      @(negedge clk);
      check("rst_lat2_out_valid", 8'(out_valid), 8'h01);
      check("rst_lat2_out_posit", out_posit, 8'h30);
      @(negedge clk);
      check("rst_drained", 8'(out_valid), 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
